// File: rtl/poly_mult_pkg.sv
// poly_mult_pkg: shared scheduler FSM state type and tile-geometry helpers.
//   num_tiles(width, tile) -> number of tiles covering a polynomial
//   idx_width(n)           -> index width for n tiles, never below 1 bit
package poly_mult_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT_MULT, FINISH} sched_state_e;
  function automatic int num_tiles(input int width, input int tile);
    return width / tile;
  endfunction
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/poly_tile_scheduler_if.sv
// poly_tile_scheduler_if: tile-memory read ports and multiplier handshake.
//   master (scheduler): drives a/b_rd_en, a/b_rd_addr, tile_a/b, tile_valid;
//                       receives a/b_rd_data (one cycle after rd_en), mult_done
//   slave  (memories + multiplier): the mirror image
interface poly_tile_scheduler_if #(
  parameter int A_TILE = 8,
  parameter int B_TILE = 8,
  parameter int DW     = 64,
  parameter int AW     = 4,
  parameter int BW     = 4
);
  logic                           a_rd_en;
  logic [AW-1:0]                  a_rd_addr;
  logic [A_TILE-1:0][DW-1:0]      a_rd_data;
  logic                           b_rd_en;
  logic [BW-1:0]                  b_rd_addr;
  logic [B_TILE-1:0][DW-1:0]      b_rd_data;
  logic [A_TILE-1:0][DW-1:0]      tile_a;
  logic [B_TILE-1:0][DW-1:0]      tile_b;
  logic                           tile_valid;
  logic                           mult_done;
  modport master (
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, tile_a, tile_b, tile_valid,
    input  a_rd_data, b_rd_data, mult_done
  );
  modport slave (
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, tile_a, tile_b, tile_valid,
    output a_rd_data, b_rd_data, mult_done
  );
endinterface

// File: rtl/poly_tile_index_counter.sv
// poly_tile_index_counter: B-inner tile pair index walk.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : restart at pair (0,0) (wins over inc_i)
//   inc_i       : advance to the next pair
//   a_idx_o, b_idx_o : current pair; last_o : current pair is the final one
module poly_tile_index_counter #(
  parameter int NUM_A = 16,
  parameter int NUM_B = 16,
  parameter int AW    = 4,
  parameter int BW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [AW-1:0] a_idx_o,
  output logic [BW-1:0] b_idx_o,
  output logic          last_o
);
  localparam logic [AW-1:0] A_MAX = AW'(NUM_A - 1);
  localparam logic [BW-1:0] B_MAX = BW'(NUM_B - 1);
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic b_wrap;
  assign b_wrap = b_q == B_MAX;
  always_comb begin
    a_d = clr_i ? '0 : (inc_i && b_wrap) ? a_q + AW'(1) : a_q;
    b_d = clr_i ? '0 : inc_i ? (b_wrap ? '0 : b_q + BW'(1)) : b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign a_idx_o = a_q;
  assign b_idx_o = b_q;
  assign last_o  = (a_q == A_MAX) && (b_q == B_MAX);
endmodule

// File: rtl/poly_tile_scheduler.sv
// poly_tile_scheduler: walks every (A tile, B tile) pair, fetching both tiles
// and handing them to the multiplier one pair at a time.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_i          : one-cycle job request, honoured only when idle
//   busy_o, done_o   : job in progress / one-cycle completion pulse
//   a_idx_o, b_idx_o : pair in flight; last_pair_o : final pair in flight
//   protocol_err_o   : sticky, mult_done seen outside WAIT_MULT
//   bus              : tile memory reads and multiplier handshake
module poly_tile_scheduler
  import poly_mult_pkg::*;
#(
  parameter int POLY_A_WIDTH      = 128,
  parameter int POLY_B_WIDTH      = 128,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8,
  parameter int DATA_WIDTH        = 64,
  localparam int NUM_A_TILES = num_tiles(POLY_A_WIDTH, POLY_A_TILE_WIDTH),
  localparam int NUM_B_TILES = num_tiles(POLY_B_WIDTH, POLY_B_TILE_WIDTH),
  localparam int A_IDX_W     = idx_width(NUM_A_TILES),
  localparam int B_IDX_W     = idx_width(NUM_B_TILES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [A_IDX_W-1:0] a_idx_o,
  output logic [B_IDX_W-1:0] b_idx_o,
  output logic               last_pair_o,
  output logic               protocol_err_o,
  poly_tile_scheduler_if.master bus
);
  if ((POLY_A_WIDTH % POLY_A_TILE_WIDTH) != 0 || (POLY_B_WIDTH % POLY_B_TILE_WIDTH) != 0) begin : g_bad_tiling
    $error("poly_tile_scheduler: polynomial widths must be whole multiples of the tile widths");
  end
  sched_state_e state_q, state_d;
  logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_a_q;
  logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_b_q;
  logic err_q, last, idx_clr, idx_inc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      tile_a_q <= '0;
      tile_b_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | (bus.mult_done && state_q != WAIT_MULT);
      if (state_q == LOAD) begin
        tile_a_q <= bus.a_rd_data;
        tile_b_q <= bus.b_rd_data;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = start_i ? FETCH : IDLE;
      FETCH:     state_d = LOAD;
      LOAD:      state_d = ISSUE;
      ISSUE:     state_d = WAIT_MULT;
      WAIT_MULT: state_d = !bus.mult_done ? WAIT_MULT : last ? FINISH : FETCH;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  assign idx_clr = (state_q == IDLE) && start_i;
  assign idx_inc = (state_q == WAIT_MULT) && bus.mult_done && !last;
  poly_tile_index_counter #(
    .NUM_A(NUM_A_TILES), .NUM_B(NUM_B_TILES), .AW(A_IDX_W), .BW(B_IDX_W)
  ) u_idx (
    .clk, .rst_n, .inc_i(idx_inc), .clr_i(idx_clr),
    .a_idx_o(a_idx_o), .b_idx_o(b_idx_o), .last_o(last)
  );
  assign busy_o         = state_q != IDLE;
  assign done_o         = state_q == FINISH;
  // Indices hold after a job ends, so the final-pair flag is gated by busy.
  assign last_pair_o    = busy_o && last;
  assign protocol_err_o = err_q;
  assign bus.a_rd_en    = state_q == FETCH;
  assign bus.b_rd_en    = state_q == FETCH;
  assign bus.a_rd_addr  = a_idx_o;
  assign bus.b_rd_addr  = b_idx_o;
  assign bus.tile_valid = state_q == ISSUE;
  assign bus.tile_a     = tile_a_q;
  assign bus.tile_b     = tile_b_q;
endmodule

// File: doc/poly_tile_scheduler.md
POLY_TILE_SCHEDULER -- requirements
Module: poly_tile_scheduler

Interface
REQ-001 SHALL have parameters: POLY_A_WIDTH, default 128, coefficients in polynomial A; POLY_B_WIDTH, default 128, coefficients in B; POLY_A_TILE_WIDTH, default 8, coefficients per A tile; POLY_B_TILE_WIDTH, default 8, coefficients per B tile; DATA_WIDTH, default 64, coefficient bits.
REQ-002 SHALL derive NUM_A_TILES=POLY_A_WIDTH/POLY_A_TILE_WIDTH, NUM_B_TILES=POLY_B_WIDTH/POLY_B_TILE_WIDTH, A_IDX_W=max(1,clog2(NUM_A_TILES)), B_IDX_W likewise.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst  in  1  asynchronous reset, asserted low.
REQ-004 start  in  1  single-cycle request to multiply full polynomials A*B.
REQ-005 busy  out  1  high from accepted start until done pulse inclusive.
REQ-006 done  out  1  one-cycle pulse after final tile pair completes.
REQ-007 a_rd_en  out  1, a_rd_addr  out  A_IDX_W: A tile memory read; data returns next cycle.
REQ-008 a_rd_data  in  POLY_A_TILE_WIDTH x DATA_WIDTH  A tile read data.
REQ-009 b_rd_en  out  1, b_rd_addr  out  B_IDX_W, b_rd_data  in  POLY_B_TILE_WIDTH x DATA_WIDTH: same for B.
REQ-010 tile_a  out  POLY_A_TILE_WIDTH x DATA_WIDTH, tile_b  out  POLY_B_TILE_WIDTH x DATA_WIDTH: registered tiles to multiplier.
REQ-011 tile_valid  out  1  one-cycle pulse driving multiplier start.
REQ-012 mult_done  in  1  multiplier completion pulse (ready_for_tile of the multiplier top).
REQ-013 a_idx  out  A_IDX_W, b_idx  out  B_IDX_W  indices of pair currently in flight; last_pair  out  1  high while final pair in flight.
REQ-014 protocol_err  out  1  sticky flag, unexpected mult_done.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, ISSUE, WAIT_MULT, FINISH.
REQ-016 IDLE: start=1 -> FETCH, indices cleared to 0, busy=1 next cycle; start in any other state SHALL be ignored.
REQ-017 FETCH: a_rd_en=b_rd_en=1 for exactly one cycle with addresses a_idx/b_idx -> LOAD.
REQ-018 LOAD: tile_a/tile_b SHALL capture a_rd_data/b_rd_data -> ISSUE; tiles SHALL hold until next LOAD.
REQ-019 ISSUE: tile_valid=1 for exactly one cycle -> WAIT_MULT; start-to-first-tile_valid latency is 3 cycles.
REQ-020 WAIT_MULT: hold until mult_done=1; then last_pair -> FINISH, else advance indices -> FETCH.
REQ-021 Order SHALL be B-inner: b_idx increments; at NUM_B_TILES-1 it wraps to 0 and a_idx increments.
REQ-022 last_pair SHALL equal (a_idx==NUM_A_TILES-1)&&(b_idx==NUM_B_TILES-1) while busy, 0 otherwise.
REQ-023 FINISH: done=1 one cycle, busy=0 next cycle -> IDLE; start in FINISH is ignored.
REQ-024 mult_done in any state other than WAIT_MULT SHALL set protocol_err and otherwise be ignored; cleared only by reset.
REQ-025 mult_done coincident with tile_valid (ISSUE) SHALL be treated per REQ-024.
REQ-026 Exactly NUM_A_TILES*NUM_B_TILES tile_valid pulses SHALL occur per start (256 at defaults).
REQ-027 Single-tile case (NUM_A_TILES=NUM_B_TILES=1) SHALL issue one pair and finish.

Reset
REQ-028 rst low SHALL immediately force IDLE; busy, done, tile_valid, a_rd_en, b_rd_en, protocol_err, last_pair, a_idx, b_idx, addresses, tile_a, tile_b all 0.
REQ-029 Reset mid-operation SHALL abandon the job; no done pulse; new start required after release.

Structure
REQ-030 FSM state enum and tile-count/index-width derivation functions SHALL live in shared package poly_mult_pkg.
REQ-031 Index advance/wrap logic SHALL be sub-module poly_tile_index_counter (inc, clr in; a_idx, b_idx, last out).
REQ-032 SHALL elaborate-time error if POLY_A_WIDTH%POLY_A_TILE_WIDTH or POLY_B_WIDTH%POLY_B_TILE_WIDTH is nonzero.

Verification
REQ-033 Defaults, model memory tile k = coefficients k*8..k*8+7, mult_done 5 cycles after each tile_valid -> 256 tile_valid, pairs (0,0),(0,1)..(15,15), one done, tile data matches addresses.
REQ-034 start at cycle 0 -> a_rd_en at cycle 1, tile_valid at cycle 3; mult_done immediately next cycle -> next tile_valid 4 cycles later.
REQ-035 start pulsed while busy and in FINISH -> ignored, total pairs remain 256, single done.
REQ-036 Spurious mult_done during FETCH -> protocol_err=1 and sticky, sequencing unaffected.
REQ-037 rst low at pair (3,7) during WAIT_MULT -> all outputs 0 immediately, no done; restart runs from (0,0).
REQ-038 POLY_A_WIDTH=POLY_A_TILE_WIDTH=8, POLY_B_WIDTH=16, POLY_B_TILE_WIDTH=8 -> pairs (0,0),(0,1), last_pair high only on second.
